// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one burst physical-memory port between the icache and
// the dcache. One cacheline transaction runs at a time. The owner keeps the
// port until pmem_resp, and ties go round-robin so neither cache can starve.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   i_pmem_*           icache side (read-only): request, address, fill data, resp
//   d_pmem_*           dcache side: read/write request, address, wdata, fill data, resp
//   pmem_*             physical memory side: read/write, address, wdata, rdata, resp
//
// pmem_read/pmem_write/pmem_address/pmem_wdata are registered. The *_pmem_resp
// and *_pmem_rdata outputs are combinational forwards of the memory response.
module cache_arbiter #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    // Latched transaction presented to physical memory while an owner holds the port.
    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] wdata;
    } txn_t;

    state_e state_q, state_d;
    grant_e last_q,  last_d;
    txn_t   txn_q,   txn_d;

    logic i_req;
    logic d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // State, fairness pointer and latched transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= GNT_I;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            txn_q   <= txn_d;
        end
    end

    // Arbitration and transaction tracking.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        txn_d   = txn_q;

        unique case (state_q)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (i_req && (!d_req || (last_q == GNT_D))) begin
                    state_d     = I_BUSY;
                    last_d      = GNT_I;
                    txn_d.rd    = 1'b1;
                    txn_d.wr    = 1'b0;
                    txn_d.addr  = i_pmem_address;
                    txn_d.wdata = '0;
                end else if (d_req) begin
                    state_d     = D_BUSY;
                    last_d      = GNT_D;
                    // An illegal read+write request is carried out as a write.
                    txn_d.rd    = d_pmem_read & ~d_pmem_write;
                    txn_d.wr    = d_pmem_write;
                    txn_d.addr  = d_pmem_address;
                    txn_d.wdata = d_pmem_wdata;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_d  = IDLE;
                    txn_d.rd = 1'b0;
                    txn_d.wr = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                txn_d.rd = 1'b0;
                txn_d.wr = 1'b0;
            end
        endcase
    end

    assign pmem_read    = txn_q.rd;
    assign pmem_write   = txn_q.wr;
    assign pmem_address = txn_q.addr;
    assign pmem_wdata   = txn_q.wdata;

    // Response goes to the current owner only; a response while idle is dropped.
    assign i_pmem_resp  = pmem_resp & (state_q == I_BUSY);
    assign d_pmem_resp  = pmem_resp & (state_q == D_BUSY);

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    // The dcache must never ask for read and write in the same cycle.
    dcache_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked each cycle against a
// transaction-level model of the arbitration rules.
module tb_cache_arbiter;

    localparam int unsigned LW = 256;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_pmem_read = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    always #5 clk = ~clk;

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 none, 1 icache, 2 dcache. last: 1 icache, 2 dcache.
    int            m_owner = 0;
    int            m_last  = 1;
    logic          m_rd = 1'b0;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wdata = '0;
    bit            m_valid = 1'b0;
    bit            m_fresh = 1'b0;

    function automatic int pick_of(input bit ir, input bit dr, input int last);
        if (ir && dr) return (last == 1) ? 2 : 1;
        if (ir) return 1;
        if (dr) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner <= 0;
            m_last  <= 1;
            m_rd    <= 1'b0;
            m_wr    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_valid <= 1'b1;
            m_fresh <= 1'b1;
        end else begin
            m_fresh <= 1'b0;
            if (m_owner == 0) begin
                case (pick_of(i_pmem_read, d_pmem_read | d_pmem_write, m_last))
                    1: begin
                        m_owner <= 1; m_last <= 1;
                        m_rd <= 1'b1; m_wr <= 1'b0;
                        m_addr <= i_pmem_address; m_wdata <= '0;
                    end
                    2: begin
                        m_owner <= 2; m_last <= 2;
                        m_rd <= d_pmem_read & ~d_pmem_write; m_wr <= d_pmem_write;
                        m_addr <= d_pmem_address; m_wdata <= d_pmem_wdata;
                    end
                    default: ;
                endcase
            end else if (pmem_resp) begin
                m_owner <= 0;
                m_rd    <= 1'b0;
                m_wr    <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("pmem_read",  LW'(pmem_read),  LW'(m_rd));
            chk("pmem_write", LW'(pmem_write), LW'(m_wr));
            if (m_owner != 0 || m_fresh) begin
                chk("pmem_address", LW'(pmem_address), LW'(m_addr));
                chk("pmem_wdata",   pmem_wdata,        m_wdata);
            end
            chk("i_pmem_resp",  LW'(i_pmem_resp), LW'(pmem_resp && m_owner == 1));
            chk("d_pmem_resp",  LW'(d_pmem_resp), LW'(pmem_resp && m_owner == 2));
            chk("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
            chk("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_pmem_read  = 1'b0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        pmem_resp    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (pmem_read || pmem_write) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    int tgt = 2;
    int cnt = 0;
    bit ok;

    initial begin
        // Icache only, plus reset values.
        do_reset();
        #1;
        chk("rst_pmem_read",    LW'(pmem_read),    LW'(0));
        chk("rst_pmem_write",   LW'(pmem_write),   LW'(0));
        chk("rst_pmem_address", LW'(pmem_address), LW'(0));
        chk("rst_pmem_wdata",   pmem_wdata,        LW'(0));
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0060;
        step(); #1;
        chk("i_only_read", LW'(pmem_read),    LW'(1));
        chk("i_only_addr", LW'(pmem_address), LW'(32'h60));
        repeat (4) step();
        pmem_resp = 1'b1; pmem_rdata = {32{8'hA5}};
        #1;
        chk("i_only_resp",   LW'(i_pmem_resp), LW'(1));
        chk("i_only_rdata",  i_pmem_rdata,     {32{8'hA5}});
        chk("i_only_d_resp", LW'(d_pmem_resp), LW'(0));
        step();
        i_pmem_read = 1'b0; pmem_resp = 1'b0;
        #1;
        chk("i_only_resp_drop", LW'(i_pmem_resp), LW'(0));
        chk("i_only_idle",      LW'(pmem_read),   LW'(0));

        // Simultaneous after reset: D first, then I after one idle cycle.
        do_reset();
        i_pmem_read = 1'b1; i_pmem_address = 32'h100;
        d_pmem_read = 1'b1; d_pmem_address = 32'h200;
        step(); #1;
        chk("tie_first_addr", LW'(pmem_address), LW'(32'h200));
        step();
        pmem_resp = 1'b1; #1;
        chk("tie_d_resp", LW'(d_pmem_resp), LW'(1));
        chk("tie_i_resp", LW'(i_pmem_resp), LW'(0));
        step();
        d_pmem_read = 1'b0; pmem_resp = 1'b0; #1;
        chk("tie_gap", LW'(pmem_read), LW'(0));
        step(); #1;
        chk("tie_second_read", LW'(pmem_read),    LW'(1));
        chk("tie_second_addr", LW'(pmem_address), LW'(32'h100));
        pmem_resp = 1'b1;
        step();
        idle_inputs();
        step();

        // Round-robin with both requesting continuously.
        do_reset();
        i_pmem_read = 1'b1; i_pmem_address = 32'h100;
        d_pmem_read = 1'b1; d_pmem_address = 32'h200;
        for (int t = 0; t < 6; t++) begin
            wait_busy(ok);
            chk("rr_grant_timeout", LW'(ok), LW'(1));
            chk("rr_order", LW'(pmem_address), LW'((t % 2 == 0) ? 32'h200 : 32'h100));
            pmem_resp = 1'b1;
            step();
            pmem_resp = 1'b0;
        end
        idle_inputs();
        step();

        // Write-back then fill, with an icache request in between.
        do_reset();
        d_pmem_write = 1'b1; d_pmem_address = 32'h340; d_pmem_wdata = 256'h1234;
        i_pmem_read = 1'b1; i_pmem_address = 32'h500;
        step(); #1;
        chk("wb_write", LW'(pmem_write),   LW'(1));
        chk("wb_read",  LW'(pmem_read),    LW'(0));
        chk("wb_addr",  LW'(pmem_address), LW'(32'h340));
        chk("wb_wdata", pmem_wdata,        256'h1234);
        pmem_resp = 1'b1; #1;
        chk("wb_d_resp", LW'(d_pmem_resp), LW'(1));
        step();
        d_pmem_write = 1'b0; d_pmem_read = 1'b1; d_pmem_address = 32'h780; pmem_resp = 1'b0;
        #1;
        chk("wb_gap", LW'(pmem_write), LW'(0));
        step(); #1;
        chk("wb_i_between", LW'(pmem_address), LW'(32'h500));
        pmem_resp = 1'b1;
        step();
        i_pmem_read = 1'b0; pmem_resp = 1'b0;
        step(); #1;
        chk("fill_read", LW'(pmem_read),    LW'(1));
        chk("fill_addr", LW'(pmem_address), LW'(32'h780));
        pmem_resp = 1'b1;
        step();
        idle_inputs();
        step();

        // Address must hold while the owner changes its inputs.
        d_pmem_read = 1'b1; d_pmem_address = 32'h40;
        step();
        d_pmem_address = 32'h80; #1;
        chk("stable_addr0", LW'(pmem_address), LW'(32'h40));
        step(); #1;
        chk("stable_addr1", LW'(pmem_address), LW'(32'h40));
        pmem_resp = 1'b1; #1;
        chk("stable_resp", LW'(d_pmem_resp), LW'(1));
        step();
        idle_inputs();
        step();

        // Reset two cycles into an icache transaction.
        i_pmem_read = 1'b1; i_pmem_address = 32'h60;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; i_pmem_read = 1'b0; pmem_resp = 1'b1; #1;
        chk("rstmid_read",   LW'(pmem_read),   LW'(0));
        chk("rstmid_i_resp", LW'(i_pmem_resp), LW'(0));
        step();
        pmem_resp = 1'b0;
        i_pmem_read = 1'b1; i_pmem_address = 32'h100;
        d_pmem_read = 1'b1; d_pmem_address = 32'h200;
        step(); #1;
        chk("rstmid_tie_addr", LW'(pmem_address), LW'(32'h200));
        pmem_resp = 1'b1;
        step();
        idle_inputs();
        step();

        // Randomized traffic with a responding memory and stray responses.
        for (int c = 0; c < 4000; c++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) i_pmem_read = ~i_pmem_read;
            i_pmem_address = $urandom & 32'hFFFF_FFE0;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
                    1: begin d_pmem_read = 1'b1; d_pmem_write = 1'b0; end
                    default: begin d_pmem_read = 1'b0; d_pmem_write = 1'b1; end
                endcase
            end
            d_pmem_address = $urandom & 32'hFFFF_FFE0;
            d_pmem_wdata   = {8{$urandom}};
            pmem_rdata     = {8{$urandom}};
            if (pmem_read || pmem_write) begin
                if (pmem_resp) begin
                    pmem_resp = 1'b0;
                    cnt = 0;
                    tgt = $urandom_range(0, 4);
                end else if (cnt >= tgt) begin
                    pmem_resp = 1'b1;
                end else begin
                    cnt++;
                end
            end else begin
                pmem_resp = ($urandom_range(0, 15) == 0);
                cnt = 0;
            end
        end
        rst = 1'b0;
        idle_inputs();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
